// File: rtl/rr_mux16_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_mux16_arbiter_pkg                                                 |
// | Shared sizes and state encoding for the round-robin mux arbiter.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package rr_mux16_arbiter_pkg;
    localparam int NUM_REQ = 16;
    localparam int SEL_W   = 4;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction
endpackage
`default_nettype wire

// File: rtl/rr_mux16_arbiter_mux16to1_2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mux16to1_2                                                           |
// | Shared 1-bit 16:1 mux built as a four-level tree of 2:1 muxes.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mux16to1_2
    import rr_mux16_arbiter_pkg::*;
(
    input  logic [SEL_W-1:0]   sel,
    input  logic [NUM_REQ-1:0] din,
    output logic               y
);
    logic [7:0] w_l1;
    logic [3:0] w_l2;
    logic [1:0] w_l3;

    generate
        for (genvar g = 0; g < 8; g++) begin : g_l1
            assign w_l1[g] = sel[0] ? din[2*g+1] : din[2*g];
        end
        for (genvar g = 0; g < 4; g++) begin : g_l2
            assign w_l2[g] = sel[1] ? w_l1[2*g+1] : w_l1[2*g];
        end
        for (genvar g = 0; g < 2; g++) begin : g_l3
            assign w_l3[g] = sel[2] ? w_l2[2*g+1] : w_l2[2*g];
        end
    endgenerate

    assign y = sel[3] ? w_l3[1] : w_l3[0];
endmodule
`default_nettype wire

// File: rtl/rr_mux16_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_mux16_arbiter                                                     |
// | Round-robin arbiter with hold limit sharing one 16:1 mux tree.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_mux16_arbiter
    import rr_mux16_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] din,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   sel,
    output logic               y,
    output logic               y_valid,
    output logic               busy
);
    localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(MAX_HOLD - 1);

    logic [0:0]         r_state;
    logic [NUM_REQ-1:0] r_gnt;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   r_ptr;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_found;
    logic [SEL_W-1:0]   w_winner;
    logic [SEL_W-1:0]   w_idx;
    logic               w_keep;
    logic               w_valid;
    logic               w_mux_y;

    // Scan from the farthest offset down so the nearest set bit to r_ptr is written last.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_idx = r_ptr + SEL_W'(i);
            if (req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_valid = (r_state == GRANT);
    assign w_keep  = w_valid && req[r_sel] && (r_cnt != c_LAST_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_sel   <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else if (w_keep) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else if (en && w_found) begin
            r_state <= GRANT;
            r_gnt   <= onehot(w_winner);
            r_sel   <= w_winner;
            r_ptr   <= w_winner + SEL_W'(1);
            r_cnt   <= '0;
        end else begin
            // sel and ptr deliberately hold their values while idle
            r_state <= IDLE;
            r_gnt   <= '0;
            r_cnt   <= '0;
        end
    end

    mux16to1_2 u_mux (
        .sel (r_sel),
        .din (din),
        .y   (w_mux_y)
    );

    assign gnt     = r_gnt;
    assign sel     = r_sel;
    assign y_valid = w_valid;
    assign busy    = w_valid;
    assign y       = w_mux_y & w_valid;
endmodule
`default_nettype wire

// File: tb/tb_rr_mux16_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rr_mux16_arbiter                                                  |
// | Directed bench with a cycle-level reference model and literal checks.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_rr_mux16_arbiter;
    localparam int MAX_HOLD = 8;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] req;
    logic [15:0] din;
    logic [15:0] gnt;
    logic [3:0]  sel;
    logic        y;
    logic        y_valid;
    logic        busy;

    int n_chk  = 0;
    int n_pass = 0;

    // Model state: who holds the grant, who was granted last, how many cycles held.
    int m_holder = -1;
    int m_last   = 15;
    int m_held   = 0;
    int m_sel    = 0;

    rr_mux16_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .req     (req),
        .din     (din),
        .gnt     (gnt),
        .sel     (sel),
        .y       (y),
        .y_valid (y_valid),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic int pick(input logic [15:0] r, input int start);
        for (int k = 0; k < 16; k++) begin
            if (r[(start + k) % 16]) return (start + k) % 16;
        end
        return -1;
    endfunction

    // Reference model advances on each rising edge, or clears on reset.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_holder = -1; m_last = 15; m_held = 0; m_sel = 0;
        end else begin
            int w;
            bit arb;
            arb = 1'b1;
            if (m_holder >= 0 && req[m_holder] && m_held < MAX_HOLD) begin
                m_held++;
                arb = 1'b0;
            end
            if (arb) begin
                w = en ? pick(req, (m_last + 1) % 16) : -1;
                if (w >= 0) begin
                    m_holder = w; m_last = w; m_sel = w; m_held = 1;
                end else begin
                    m_holder = -1; m_held = 0;
                end
            end
        end
    end

    // Compare DUT against model every cycle on the falling edge.
    initial forever begin
        logic [22:0] exp_v, act_v;
        logic [15:0] eg;
        logic        ev;
        @(negedge clk);
        ev    = (m_holder >= 0);
        eg    = ev ? (16'h1 << m_holder) : 16'h0;
        exp_v = {eg, 4'(m_sel), ev, ev, ev & din[m_sel]};
        act_v = {gnt, sel, y_valid, busy, y};
        check("model {gnt,sel,valid,busy,y}", 32'(act_v), 32'(exp_v));
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; en = 1'b0;
        cyc(2);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; req = '0; din = '0;
        cyc(2);
        rst = 1'b0;
        check("reset gnt", 32'(gnt), 32'h0);
        check("reset valid", 32'(y_valid), 32'h0);

        // 1: single request, data path, release
        req = 16'h0020; en = 1'b1; din = 16'h0020;
        cyc(1);
        check("t1 gnt", 32'(gnt), 32'h0020);
        check("t1 sel", 32'(sel), 32'd5);
        check("t1 y high", 32'(y), 32'h1);
        din = 16'hFFDF; #1;
        check("t1 y low", 32'(y), 32'h0);
        req = 16'h0000;
        cyc(1);
        check("t1 release gnt", 32'(gnt), 32'h0);
        check("t1 release valid", 32'(y_valid), 32'h0);
        check("t1 release y", 32'(y), 32'h0);

        // 2: back-to-back handover and pointer wrap
        do_reset();
        req = 16'h8001; en = 1'b1; din = 16'hA5C3;
        cyc(1);
        check("t2 first sel", 32'(sel), 32'd0);
        cyc(2);
        req = 16'h8000;
        cyc(1);
        check("t2 handover gnt", 32'(gnt), 32'h8000);
        check("t2 handover valid", 32'(y_valid), 32'h1);
        req = 16'h8001;
        cyc(1);
        req = 16'h0001;
        cyc(1);
        check("t2 wrap gnt", 32'(gnt), 32'h0001);
        req = 16'h0000;
        cyc(1);

        // 3: two contenders alternate every MAX_HOLD cycles
        do_reset();
        req = 16'h0088; en = 1'b1; din = 16'h0080;
        cyc(1);
        for (int k = 0; k < 3 * MAX_HOLD; k++) begin
            check("t3 sel", 32'(sel), ((k / MAX_HOLD) % 2) ? 32'd7 : 32'd3);
            check("t3 valid", 32'(y_valid), 32'h1);
            cyc(1);
        end

        // 4: lone requester is regranted on every timeout
        do_reset();
        req = 16'h0200; en = 1'b1;
        cyc(1);
        for (int k = 0; k < 20; k++) begin
            check("t4 sel", 32'(sel), 32'd9);
            check("t4 cnt", 32'(dut.r_cnt), 32'(k % MAX_HOLD));
            cyc(1);
        end

        // 5: enable gating
        do_reset();
        req = 16'hFFFF; en = 1'b0; din = 16'h0001;
        cyc(3);
        check("t5 blocked gnt", 32'(gnt), 32'h0);
        en = 1'b1;
        cyc(1);
        check("t5 first gnt", 32'(gnt), 32'h0001);
        cyc(2);
        en = 1'b0;
        cyc(5);
        check("t5 last held gnt", 32'(gnt), 32'h0001);
        cyc(1);
        check("t5 timeout idle gnt", 32'(gnt), 32'h0);
        check("t5 timeout idle valid", 32'(y_valid), 32'h0);
        cyc(2);

        // 6: asynchronous reset mid-grant
        en = 1'b1; req = 16'h0010; din = 16'hFFFF;
        cyc(2);
        check("t6 pre gnt", 32'(gnt), 32'h0010);
        #3 rst = 1'b1;
        #1;
        check("t6 async gnt", 32'(gnt), 32'h0);
        check("t6 async sel", 32'(sel), 32'h0);
        check("t6 async valid", 32'(y_valid), 32'h0);
        check("t6 async y", 32'(y), 32'h0);
        req = 16'h1000;
        cyc(1);
        rst = 1'b0;
        cyc(1);
        check("t6 post gnt", 32'(gnt), 32'h1000);
        check("t6 post sel", 32'(sel), 32'd12);
        req = 16'h0000;
        cyc(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
